// File: rtl/axi_lite_to_reg.sv
// AXI4-Lite subordinate to register-interface bridge: one outstanding transaction,
// round-robin read/write arbitration and an optional response timeout.
package axi_lite_to_reg_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;
endpackage

module axi_lite_to_reg #(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 0,
  parameter type         reg_req_t     = axi_lite_to_reg_pkg::reg_req_t,
  parameter type         reg_rsp_t     = axi_lite_to_reg_pkg::reg_rsp_t
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [AddrWidth-1:0]   aw_addr_i,
  input  logic                   aw_valid_i,
  output logic                   aw_ready_o,
  input  logic [DataWidth-1:0]   w_data_i,
  input  logic [DataWidth/8-1:0] w_strb_i,
  input  logic                   w_valid_i,
  output logic                   w_ready_o,
  output logic [1:0]             b_resp_o,
  output logic                   b_valid_o,
  input  logic                   b_ready_i,
  input  logic [AddrWidth-1:0]   ar_addr_i,
  input  logic                   ar_valid_i,
  output logic                   ar_ready_o,
  output logic [DataWidth-1:0]   r_data_o,
  output logic [1:0]             r_resp_o,
  output logic                   r_valid_o,
  input  logic                   r_ready_i,
  output reg_req_t               reg_req_o,
  input  reg_rsp_t               reg_rsp_i
);

  localparam int unsigned CntW   = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam int unsigned ToLast = (TimeoutCycles > 0) ? TimeoutCycles - 1 : 0;
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlvErr = 2'b10;

  typedef enum logic [2:0] {IDLE, WRITE, READ, WRESP, RRESP} state_e;

  state_e                 state_q, state_d;
  logic                   last_wr_q, last_wr_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic                   write_q, write_d;
  logic [DataWidth-1:0]   wdata_q, wdata_d;
  logic [DataWidth/8-1:0] wstrb_q, wstrb_d;
  logic [1:0]             b_resp_q, b_resp_d;
  logic [1:0]             r_resp_q, r_resp_d;
  logic [DataWidth-1:0]   r_data_q, r_data_d;
  logic [CntW-1:0]        cnt_q, cnt_d;

  logic wr_elig, rd_elig, timeout_hit;
  logic [1:0] rsp_code;

  always_comb begin
    state_d    = state_q;
    last_wr_d  = last_wr_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    b_resp_d   = b_resp_q;
    r_resp_d   = r_resp_q;
    r_data_d   = r_data_q;
    cnt_d      = cnt_q;
    aw_ready_o = 1'b0;
    w_ready_o  = 1'b0;
    ar_ready_o = 1'b0;

    wr_elig     = aw_valid_i && w_valid_i;
    rd_elig     = ar_valid_i;
    timeout_hit = (TimeoutCycles != 0) && (cnt_q == ToLast[CntW-1:0]);
    rsp_code    = reg_rsp_i.error ? RespSlvErr : RespOkay;

    case (state_q)
      IDLE: begin
        // On a tie the kind that did not win last time is granted.
        if (wr_elig && (!rd_elig || !last_wr_q)) begin
          aw_ready_o = 1'b1;
          w_ready_o  = 1'b1;
          addr_d     = aw_addr_i;
          wdata_d    = w_data_i;
          wstrb_d    = w_strb_i;
          write_d    = 1'b1;
          last_wr_d  = 1'b1;
          state_d    = WRITE;
        end else if (rd_elig) begin
          ar_ready_o = 1'b1;
          addr_d     = ar_addr_i;
          write_d    = 1'b0;
          last_wr_d  = 1'b0;
          state_d    = READ;
        end
      end
      WRITE, READ: begin
        if (reg_rsp_i.ready) begin
          cnt_d = '0;
          if (state_q == WRITE) begin
            b_resp_d = rsp_code;
            state_d  = WRESP;
          end else begin
            r_resp_d = rsp_code;
            r_data_d = reg_rsp_i.rdata;
            state_d  = RRESP;
          end
        end else if (timeout_hit) begin
          // Silent peripheral: abort with SLVERR and no read data.
          cnt_d = '0;
          if (state_q == WRITE) begin
            b_resp_d = RespSlvErr;
            state_d  = WRESP;
          end else begin
            r_resp_d = RespSlvErr;
            r_data_d = '0;
            state_d  = RRESP;
          end
        end else if (TimeoutCycles != 0) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      WRESP: if (b_ready_i) state_d = IDLE;
      RRESP: if (r_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      last_wr_q <= 1'b0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      b_resp_q  <= '0;
      r_resp_q  <= '0;
      r_data_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      b_resp_q  <= b_resp_d;
      r_resp_q  <= r_resp_d;
      r_data_q  <= r_data_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    reg_req_o       = '0;
    reg_req_o.addr  = addr_q;
    reg_req_o.write = write_q;
    reg_req_o.wdata = wdata_q;
    reg_req_o.wstrb = wstrb_q;
    reg_req_o.valid = (state_q == WRITE) || (state_q == READ);
  end

  assign b_valid_o = (state_q == WRESP);
  assign b_resp_o  = b_resp_q;
  assign r_valid_o = (state_q == RRESP);
  assign r_resp_o  = r_resp_q;
  assign r_data_o  = r_data_q;

endmodule

// File: tb/tb_axi_lite_to_reg.sv
// Scoreboard bench for axi_lite_to_reg: randomized and directed AXI-Lite traffic,
// a register slave model, and monitors comparing against a transaction-level model.
`timescale 1ns/1ps
module tb_axi_lite_to_reg;
  import axi_lite_to_reg_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] aw_addr_i, w_data_i, ar_addr_i;
  logic [3:0]  w_strb_i;
  logic        aw_valid_i, w_valid_i, ar_valid_i, b_ready_i, r_ready_i;
  logic        aw_ready_o, w_ready_o, ar_ready_o, b_valid_o, r_valid_o;
  logic [1:0]  b_resp_o, r_resp_o;
  logic [31:0] r_data_o;
  reg_req_t    reg_req_o;
  reg_rsp_t    reg_rsp_i;

  axi_lite_to_reg #(.AddrWidth(32), .DataWidth(32), .TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .aw_addr_i(aw_addr_i), .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
    .w_data_i(w_data_i), .w_strb_i(w_strb_i), .w_valid_i(w_valid_i), .w_ready_o(w_ready_o),
    .b_resp_o(b_resp_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
    .ar_addr_i(ar_addr_i), .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o),
    .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
    .reg_req_o(reg_req_o), .reg_rsp_i(reg_rsp_i)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic write; logic [31:0] wdata; logic [3:0] wstrb; int len; } req_t;
  typedef struct { int delay; logic [31:0] rdata; logic err; } plan_t;
  typedef struct { logic write; logic [1:0] resp; logic [31:0] data; } rsp_t;

  req_t  req_q[$];
  plan_t plan_q[$];
  rsp_t  rsp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rdy_mode = 1;  // 0 random, 1 always ready, 2 never ready

  // Reference model state: who won last, and the last latched write payload.
  bit          last_w;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;

  plan_t s_cur;
  bit    s_busy = 1'b0;
  int    s_wait = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    last_w  = 1'b0;
    m_wdata = '0;
    m_wstrb = '0;
  endtask

  // abort: 0 normal, 1 reset during request (no length check, no response), 2 reset during response
  task automatic push_txn(input bit w, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int delay, input logic [31:0] rdata,
                          input bit err, input int abort);
    req_t r; plan_t p; rsp_t s; bit tmo;
    tmo = (delay >= TO);
    if (w) begin
      m_wdata = wdata;
      m_wstrb = wstrb;
    end
    r.addr = addr; r.write = w; r.wdata = m_wdata; r.wstrb = m_wstrb;
    r.len = (abort == 1) ? -1 : (tmo ? TO : delay + 1);
    req_q.push_back(r);
    p.delay = delay; p.rdata = rdata; p.err = err;
    plan_q.push_back(p);
    s.write = w;
    s.resp  = (tmo || err) ? 2'b10 : 2'b00;
    s.data  = (w || tmo) ? 32'h0 : rdata;
    if (abort == 0) rsp_q.push_back(s);
    last_w = w;
  endtask

  task automatic xfer(input bit dow, input bit dor,
                      input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                      input int wdl, input bit we,
                      input logic [31:0] ra, input int rdl, input logic [31:0] rd, input bit re);
    bit wfirst, wdone, rdone, acc_w, acc_r;
    int guard;
    wfirst = dow && (!dor || !last_w);
    if (wfirst) push_txn(1'b1, wa, wd, ws, wdl, $urandom, we, 0);
    if (dor) push_txn(1'b0, ra, 32'h0, 4'h0, rdl, rd, re, 0);
    if (dow && !wfirst) push_txn(1'b1, wa, wd, ws, wdl, $urandom, we, 0);
    aw_addr_i = wa; w_data_i = wd; w_strb_i = ws; ar_addr_i = ra;
    aw_valid_i = dow; w_valid_i = dow; ar_valid_i = dor;
    wdone = !dow; rdone = !dor; guard = 0;
    while (!(wdone && rdone) && guard < 300) begin
      @(negedge clk);
      acc_w = aw_ready_o && w_ready_o;
      acc_r = ar_ready_o;
      tick();
      if (acc_w) begin wdone = 1'b1; aw_valid_i = 1'b0; w_valid_i = 1'b0; end
      if (acc_r) begin rdone = 1'b1; ar_valid_i = 1'b0; end
      guard++;
    end
    if (!(wdone && rdone)) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_quiet();
    int g = 0;
    while ((rsp_q.size() != 0 || reg_req_o.valid || b_valid_o || r_valid_o) && g < 1000) begin
      tick();
      g++;
    end
    if (g >= 1000) chk("quiet_timeout", 64'd0, 64'd1);
  endtask

  function automatic int rand_delay();
    if ($urandom_range(0, 7) == 0) return $urandom_range(4, 10);
    return $urandom_range(0, 3);
  endfunction

  task automatic pop_rsp(input bit w, input logic [1:0] resp, input logic [31:0] data);
    rsp_t s;
    if (rsp_q.size() == 0) begin
      chk(w ? "unexpected_b" : "unexpected_r", 64'd1, 64'd0);
    end else begin
      s = rsp_q.pop_front();
      chk("rsp_kind", w, s.write);
      chk(w ? "b_resp" : "r_resp", resp, s.resp);
      if (!w) chk("r_data", data, s.data);
    end
  endtask

  // Response readies
  initial begin
    b_ready_i = 1'b0;
    r_ready_i = 1'b0;
    forever begin
      tick();
      case (rdy_mode)
        0: begin b_ready_i = ($urandom & 3) != 0; r_ready_i = ($urandom & 3) != 0; end
        1: begin b_ready_i = 1'b1; r_ready_i = 1'b1; end
        default: begin b_ready_i = 1'b0; r_ready_i = 1'b0; end
      endcase
    end
  end

  // Register slave: answers each request after its planned number of wait cycles
  initial begin
    reg_rsp_i = '0;
    forever begin
      @(negedge clk);
      if (reg_req_o.valid) begin
        if (!s_busy) begin
          if (plan_q.size() != 0) s_cur = plan_q.pop_front();
          else s_cur.delay = 1000;
          s_busy = 1'b1;
          s_wait = 0;
        end else begin
          s_wait++;
        end
        if (s_wait == s_cur.delay) begin
          reg_rsp_i = '{rdata: s_cur.rdata, error: s_cur.err, ready: 1'b1};
        end else begin
          reg_rsp_i = '{rdata: $urandom, error: 1'($urandom), ready: 1'b0};
        end
      end else begin
        s_busy = 1'b0;
        reg_rsp_i.ready = 1'b0;
      end
    end
  end

  // Request monitor
  initial begin
    bit   prev = 1'b0;
    int   len = 0;
    req_t cur;
    cur.len = -1;
    forever begin
      @(negedge clk);
      if (aw_ready_o || w_ready_o)
        chk("aw_w_join", {aw_ready_o, w_ready_o, aw_valid_i, w_valid_i}, 64'hF);
      if (ar_ready_o)
        chk("ar_ready_idle", {reg_req_o.valid, b_valid_o, r_valid_o}, 64'h0);
      if (reg_req_o.valid && !prev) begin
        if (req_q.size() == 0) begin
          chk("unexpected_req", 64'd1, 64'd0);
          cur.len = -1;
        end else begin
          cur = req_q.pop_front();
          chk("req_addr", reg_req_o.addr, cur.addr);
          chk("req_write", reg_req_o.write, cur.write);
          chk("req_wdata", reg_req_o.wdata, cur.wdata);
          chk("req_wstrb", reg_req_o.wstrb, cur.wstrb);
        end
        len = 0;
      end
      if (reg_req_o.valid) len++;
      if (!reg_req_o.valid && prev && cur.len >= 0) chk("req_len", len, cur.len);
      prev = reg_req_o.valid;
    end
  end

  // Response monitor
  initial begin
    forever begin
      @(negedge clk);
      if (b_valid_o && b_ready_i) pop_rsp(1'b1, b_resp_o, 32'h0);
      if (r_valid_o && r_ready_i) pop_rsp(1'b0, r_resp_o, r_data_o);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  initial begin
    bit   acc, first_w, kw;
    int   g, grants;
    int   t_acc[4];
    logic [31:0] wd;

    rst_i = 1'b1;
    aw_addr_i = '0; w_data_i = '0; w_strb_i = '0; ar_addr_i = '0;
    aw_valid_i = 1'b0; w_valid_i = 1'b0; ar_valid_i = 1'b0;
    model_reset();
    repeat (3) tick();
    @(negedge clk);
    chk("rst_readies", {aw_ready_o, w_ready_o, ar_ready_o}, 64'h0);
    chk("rst_valids", {b_valid_o, r_valid_o, reg_req_o.valid}, 64'h0);
    chk("rst_resp", {b_resp_o, r_resp_o}, 64'h0);
    chk("rst_rdata", r_data_o, 64'h0);
    chk("rst_req_fields", {reg_req_o.addr, reg_req_o.wdata}, 64'h0);
    chk("rst_req_ctl", {reg_req_o.write, reg_req_o.wstrb}, 64'h0);
    tick();
    rst_i = 1'b0;
    tick();

    // Minimum latency write, then back-to-back read
    rdy_mode = 1;
    tick(); tick();
    push_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0, 0);
    aw_addr_i = 32'h10; w_data_i = 32'hDEADBEEF; w_strb_i = 4'hF;
    aw_valid_i = 1'b1; w_valid_i = 1'b1;
    @(negedge clk);
    chk("lat_aw_ready_c0", aw_ready_o, 64'd1);
    tick();
    aw_valid_i = 1'b0; w_valid_i = 1'b0;
    @(negedge clk);
    chk("lat_req_valid_c1", reg_req_o.valid, 64'd1);
    tick();
    push_txn(1'b0, 32'h14, 32'h0, 4'h0, 0, 32'hCAFE0001, 1'b0, 0);
    ar_addr_i = 32'h14; ar_valid_i = 1'b1;
    @(negedge clk);
    chk("lat_b_valid_c2", b_valid_o, 64'd1);
    chk("lat_ar_busy_c2", ar_ready_o, 64'd0);
    tick();
    @(negedge clk);
    chk("lat_ar_ready_c3", ar_ready_o, 64'd1);
    tick();
    ar_valid_i = 1'b0;

    // Read with 4 wait cycles and an error
    wait_quiet();
    xfer(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 0, 1'b0, 32'h20, 4, 32'h12345678, 1'b1);

    // AW without W must not be accepted; the read goes first
    wait_quiet();
    wd = $urandom;
    push_txn(1'b0, 32'h30, 32'h0, 4'h0, 2, 32'hA5A50030, 1'b0, 0);
    push_txn(1'b1, 32'h40, wd, 4'h3, 1, 32'h0, 1'b0, 0);
    aw_addr_i = 32'h40; w_data_i = wd; w_strb_i = 4'h3; ar_addr_i = 32'h30;
    aw_valid_i = 1'b1; w_valid_i = 1'b0;
    g = 0;
    while (rsp_q.size() > 1 && g < 100) begin
      if (g == 2) ar_valid_i = 1'b1;
      @(negedge clk);
      chk("aw_alone_held", aw_ready_o, 64'd0);
      acc = ar_ready_o;
      tick();
      if (acc) ar_valid_i = 1'b0;
      g++;
    end
    if (g >= 100) chk("aw_alone_timeout", 64'd0, 64'd1);
    w_valid_i = 1'b1;
    g = 0; acc = 1'b0;
    while (!acc && g < 100) begin
      @(negedge clk);
      acc = aw_ready_o;
      tick();
      g++;
    end
    aw_valid_i = 1'b0; w_valid_i = 1'b0;
    if (!acc) chk("aw_late_timeout", 64'd0, 64'd1);

    // Continuous contention: alternating grants every 3 cycles
    wait_quiet();
    first_w = !last_w;
    wd = $urandom;
    for (int k = 0; k < 4; k++) begin
      kw = first_w ^ k[0];
      if (kw) push_txn(1'b1, 32'h80, wd, 4'hC, 0, 32'h0, 1'b0, 0);
      else    push_txn(1'b0, 32'h90, 32'h0, 4'h0, 0, 32'h1000 + k, 1'b0, 0);
    end
    aw_addr_i = 32'h80; w_data_i = wd; w_strb_i = 4'hC; ar_addr_i = 32'h90;
    aw_valid_i = 1'b1; w_valid_i = 1'b1; ar_valid_i = 1'b1;
    grants = 0; g = 0;
    while (grants < 4 && g < 100) begin
      @(negedge clk);
      if (aw_ready_o || ar_ready_o) begin
        chk("thru_kind", aw_ready_o, first_w ^ grants[0]);
        t_acc[grants] = cyc;
        grants++;
      end
      tick();
      g++;
    end
    aw_valid_i = 1'b0; w_valid_i = 1'b0; ar_valid_i = 1'b0;
    if (grants < 4) chk("thru_timeout", 64'd0, 64'd1);
    else for (int k = 1; k < 4; k++) chk("thru_spacing", t_acc[k] - t_acc[k-1], 64'd3);

    // Timeout on a silent slave, then ready on the last allowed cycle
    wait_quiet();
    xfer(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 0, 1'b0, 32'h50, 20, 32'hFFFF0000, 1'b0);
    wait_quiet();
    xfer(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 0, 1'b0, 32'h54, TO - 1, 32'h0BADF00D, 1'b0);
    wait_quiet();
    xfer(1'b1, 1'b0, 32'h58, 32'h11223344, 4'h5, TO + 1, 1'b0, 32'h0, 0, 32'h0, 1'b0);

    // Randomized traffic with backpressure
    rdy_mode = 0;
    for (int i = 0; i < 60; i++) begin
      int kind;
      kind = $urandom_range(0, 2);
      xfer(kind != 1, kind != 0, $urandom, $urandom, 4'($urandom), rand_delay(), 1'($urandom),
           $urandom, rand_delay(), $urandom, 1'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) tick();
    end

    // Reset while a write request is pending
    wait_quiet();
    rdy_mode = 1;
    tick();
    push_txn(1'b1, 32'h60, 32'h76543210, 4'hF, 50, 32'h0, 1'b0, 1);
    aw_addr_i = 32'h60; w_data_i = 32'h76543210; w_strb_i = 4'hF;
    aw_valid_i = 1'b1; w_valid_i = 1'b1;
    @(negedge clk);
    acc = aw_ready_o;
    tick();
    aw_valid_i = 1'b0; w_valid_i = 1'b0;
    chk("rstw_accept", acc, 64'd1);
    @(negedge clk);
    chk("rstw_in_write", reg_req_o.valid, 64'd1);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rstw_valids", {reg_req_o.valid, b_valid_o, r_valid_o}, 64'h0);
    chk("rstw_req_cleared", {reg_req_o.addr, reg_req_o.wdata}, 64'h0);
    repeat (12) tick();
    chk("rstw_no_b", b_valid_o, 64'd0);

    // Reset while a read response is stalled
    rdy_mode = 2;
    tick(); tick();
    push_txn(1'b0, 32'h70, 32'h0, 4'h0, 0, 32'h89ABCDEF, 1'b0, 2);
    xfer_read_only: begin
      ar_addr_i = 32'h70; ar_valid_i = 1'b1;
      g = 0; acc = 1'b0;
      while (!acc && g < 50) begin
        @(negedge clk);
        acc = ar_ready_o;
        tick();
        g++;
      end
      ar_valid_i = 1'b0;
    end
    g = 0;
    while (!r_valid_o && g < 50) begin tick(); g++; end
    chk("rstr_in_rresp", r_valid_o, 64'd1);
    tick(); tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rstr_valids", {reg_req_o.valid, b_valid_o, r_valid_o}, 64'h0);
    chk("rstr_rdata", {r_resp_o, r_data_o}, 64'h0);
    rdy_mode = 1;
    repeat (6) tick();

    // After reset write must win the first tie again
    xfer(1'b1, 1'b1, 32'hA0, 32'h5A5A5A5A, 4'h9, 1, 1'b0, 32'hB0, 0, 32'h600DCAFE, 1'b0);
    wait_quiet();

    chk("queues_drained", req_q.size() + plan_q.size() + rsp_q.size(), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
